pipeline_stall_ctrl: RTL

Pipeline sequencing controller for the filter processor's 5-stage pipe (F, Reg, Exe, Mem, WB). It covers the hazards that forwarding cannot resolve: load-use, taken branch, and multi-cycle data-memory access. It drives per-stage stall (hold pipeline register) and flush (inject bubble) signals, and works alongside the forwarding unit.

---
 rtl/pipeline_stall_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush sequencing for the 5-stage filter pipe
//
// Resolves the hazards forwarding cannot: load-use, taken branch and
// multi-cycle data-memory access. All outputs are Mealy (state + inputs).
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> stall_count counts cycles with stall_F=1, saturating at 16'hFFFF
//   undefined -> stall_count tied to 16'h0000
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   Ra_F_Reg, Rb_F_Reg            source registers of the Reg-stage instruction
//   RE_A_F_Reg, RE_B_F_Reg        source read enables
//   Robj_Reg_Exe, WE_Reg_Exe      destination / write enable of the Exe instruction
//   mem_RE_Reg_Exe                Exe instruction is a load
//   branch_taken_Exe              branch resolved taken in Exe
//   mem_req_Mem, mem_ack          data-memory request / completion
//   stall_F..stall_Mem            per-stage hold
//   flush_F, flush_Reg            per-stage bubble injection
//   mem_err                       one-cycle pulse on memory timeout
//   stall_count                   stalled-cycle statistic
module pipeline_stall_ctrl #(
  parameter int REG_W       = 4,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Ra_F_Reg,
  input  logic [REG_W-1:0] Rb_F_Reg,
  input  logic             RE_A_F_Reg,
  input  logic             RE_B_F_Reg,
  input  logic [REG_W-1:0] Robj_Reg_Exe,
  input  logic             WE_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken_Exe,
  input  logic             mem_req_Mem,
  input  logic             mem_ack,
  output logic             stall_F,
  output logic             stall_Reg,
  output logic             stall_Exe,
  output logic             stall_Mem,
  output logic             flush_F,
  output logic             flush_Reg,
  output logic             mem_err,
  output logic [15:0]      stall_count
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [2:0] load_cnt, load_cnt_nxt;
  logic       mem_wait, load_use, timeout;
  logic       st_front, st_back, fl_f, fl_reg, err;

  assign mem_wait = mem_req_Mem && !mem_ack;
  assign load_use = mem_RE_Reg_Exe && WE_Reg_Exe &&
                    ((RE_A_F_Reg && (Ra_F_Reg == Robj_Reg_Exe)) ||
                     (RE_B_F_Reg && (Rb_F_Reg == Robj_Reg_Exe)));
  // The entry cycle in RUN is the first wait cycle, so the counter lags the
  // number of elapsed wait cycles by one; compare against the next value.
  assign timeout  = ({1'b0, wait_cnt} + 9'd1) >= 9'(MEM_TIMEOUT);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load_cnt_nxt = load_cnt;
    st_front     = 1'b0;
    st_back      = 1'b0;
    fl_f         = 1'b0;
    fl_reg       = 1'b0;
    err          = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          st_front     = 1'b1;
          st_back      = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (branch_taken_Exe) begin
          // Reg instruction is killed, so any load-use match is moot.
          fl_f   = 1'b1;
          fl_reg = 1'b1;
        end else if (load_use) begin
          st_front = 1'b1;
          fl_reg   = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt    = LOAD_STALL;
            load_cnt_nxt = 3'(LOAD_LAT - 1);
          end
        end
      end
      LOAD_STALL: begin
        if (mem_wait) begin
          // The load has moved on; remaining bubbles are no longer needed.
          st_front     = 1'b1;
          st_back      = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
          load_cnt_nxt = 3'd0;
        end else if (branch_taken_Exe) begin
          fl_f         = 1'b1;
          fl_reg       = 1'b1;
          state_nxt    = RUN;
          load_cnt_nxt = 3'd0;
        end else begin
          st_front = 1'b1;
          fl_reg   = 1'b1;
          if (load_cnt <= 3'd1) begin
            state_nxt    = RUN;
            load_cnt_nxt = 3'd0;
          end else begin
            load_cnt_nxt = load_cnt - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        // A dropped request is released like an ack.
        if (!mem_req_Mem || mem_ack) begin
          state_nxt = RUN;
        end else if (timeout) begin
          err       = 1'b1;
          state_nxt = RUN;
        end else begin
          st_front     = 1'b1;
          st_back      = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      load_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      load_cnt <= load_cnt_nxt;
    end
  end

  // Outputs are combinational from inputs, so gate them with reset directly.
  assign stall_F   = rst_n & st_front;
  assign stall_Reg = rst_n & st_front;
  assign stall_Exe = rst_n & st_back;
  assign stall_Mem = rst_n & st_back;
  assign flush_F   = rst_n & fl_f;
  assign flush_Reg = rst_n & fl_reg;
  assign mem_err   = rst_n & err;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall_F && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule
